// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if
//   Two-port register access bus shared by reg_bank_arbiter and its requesters.
//   Port A is the SPI-side requester, port B the internal requester.
//   Per port: req, we, addr[7:0], wdata[7:0], lock driven by the master;
//             ack (one-cycle pulse) and rdata[7:0] driven by the slave.
//   modport master : requester view
//   modport slave  : arbiter view
interface reg_bank_arbiter_if;
    logic       req_a;
    logic       we_a;
    logic [7:0] addr_a;
    logic [7:0] wdata_a;
    logic       lock_a;
    logic       ack_a;
    logic [7:0] rdata_a;

    logic       req_b;
    logic       we_b;
    logic [7:0] addr_b;
    logic [7:0] wdata_b;
    logic       lock_b;
    logic       ack_b;
    logic [7:0] rdata_b;

    modport master (
        output req_a, we_a, addr_a, wdata_a, lock_a,
        output req_b, we_b, addr_b, wdata_b, lock_b,
        input  ack_a, rdata_a,
        input  ack_b, rdata_b
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a, lock_a,
        input  req_b, we_b, addr_b, wdata_b, lock_b,
        output ack_a, rdata_a,
        output ack_b, rdata_b
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Byte register bank shared by two requesters through a round-robin arbiter.
//   Addresses 0..RW_REG_COUNT-1 are read-write bank bytes, the next
//   RO_REG_COUNT addresses read ro_data, anything above reads 8'hFF and
//   ignores writes. One access per grant; ack follows the grant by one cycle.
//
//   Optional feature: define REG_ARB_LOCK_EN to let a port holding lock keep
//   the bank for up to LOCK_MAX consecutive grants.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : reg_bank_arbiter_if.slave, both request/ack ports
//   ro_data : RO_REG_COUNT*8 read-only bytes, byte i at [8i+7:8i]
//   rw_data : RW_REG_COUNT*8 register bank, byte i at [8i+7:8i]
module reg_bank_arbiter #(
    parameter int unsigned RW_REG_COUNT = 12,
    parameter int unsigned RO_REG_COUNT = 1,
    parameter int unsigned LOCK_MAX     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    reg_bank_arbiter_if.slave         bus,
    input  logic [RO_REG_COUNT*8-1:0] ro_data,
    output logic [RW_REG_COUNT*8-1:0] rw_data
);

    typedef enum logic { IDLE, ACK } state_t;
    typedef enum logic { PORT_A, PORT_B } port_t;

    state_t     state;
    port_t      last;
    port_t      grant;
    logic       g_we;
    logic [7:0] g_addr;
    logic [7:0] g_wdata;
    logic [7:0] rd_byte;

`ifdef REG_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic [CNT_W-1:0] lock_cnt;
    port_t            lock_owner;
    logic             g_lock;
`else
    logic unused_lock;
    assign unused_lock = bus.lock_a ^ bus.lock_b;
`endif

    // Port selection and the granted request's fields.
    always_comb begin
        grant = PORT_A;
        if (bus.req_a && bus.req_b) begin
            grant = (last == PORT_A) ? PORT_B : PORT_A;
`ifdef REG_ARB_LOCK_EN
            // Owner of an unexpired lock streak wins the tie; once the streak
            // reaches LOCK_MAX the round-robin choice (the other port) stands.
            if (lock_cnt != '0 && lock_cnt < LOCK_MAX_C)
                grant = lock_owner;
`endif
        end else if (bus.req_b) begin
            grant = PORT_B;
        end

        g_we    = (grant == PORT_A) ? bus.we_a    : bus.we_b;
        g_addr  = (grant == PORT_A) ? bus.addr_a  : bus.addr_b;
        g_wdata = (grant == PORT_A) ? bus.wdata_a : bus.wdata_b;
`ifdef REG_ARB_LOCK_EN
        g_lock  = (grant == PORT_A) ? bus.lock_a  : bus.lock_b;
`endif
    end

    // Read decode: bank, then read-only bytes, then unmapped.
    always_comb begin
        rd_byte = 8'hFF;
        for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
            if ({24'd0, g_addr} == i)
                rd_byte = rw_data[i*8 +: 8];
        end
        for (int unsigned i = 0; i < RO_REG_COUNT; i++) begin
            if ({24'd0, g_addr} == RW_REG_COUNT + i)
                rd_byte = ro_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= PORT_B;
            rw_data     <= '0;
            bus.ack_a   <= 1'b0;
            bus.ack_b   <= 1'b0;
            bus.rdata_a <= '0;
            bus.rdata_b <= '0;
`ifdef REG_ARB_LOCK_EN
            lock_cnt    <= '0;
            lock_owner  <= PORT_A;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bus.ack_a <= 1'b0;
                    bus.ack_b <= 1'b0;
                    if (bus.req_a || bus.req_b) begin
                        state <= ACK;
                        last  <= grant;
                        if (grant == PORT_A)
                            bus.ack_a <= 1'b1;
                        else
                            bus.ack_b <= 1'b1;

                        if (g_we) begin
                            for (int unsigned i = 0; i < RW_REG_COUNT; i++) begin
                                if ({24'd0, g_addr} == i)
                                    rw_data[i*8 +: 8] <= g_wdata;
                            end
                        end else if (grant == PORT_A) begin
                            bus.rdata_a <= rd_byte;
                        end else begin
                            bus.rdata_b <= rd_byte;
                        end

`ifdef REG_ARB_LOCK_EN
                        // Count consecutive locked grants to the same port;
                        // saturates when nobody else is competing.
                        if (g_lock) begin
                            if (lock_cnt != '0 && lock_owner == grant)
                                lock_cnt <= (lock_cnt == LOCK_MAX_C) ? LOCK_MAX_C
                                                                     : lock_cnt + CNT_W'(1);
                            else
                                lock_cnt <= CNT_W'(1);
                            lock_owner <= grant;
                        end else begin
                            lock_cnt <= '0;
                        end
`endif
                    end
                end
                ACK: begin
                    bus.ack_a <= 1'b0;
                    bus.ack_b <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
//   Directed scenarios followed by randomized two-port traffic, every cycle
//   compared against a transaction-level model of the arbiter and bank.
module tb_reg_bank_arbiter;

    localparam int RW       = 12;
    localparam int RO       = 1;
    localparam int LOCK_MAX = 4;
`ifdef REG_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [RO*8-1:0] ro_data;
    logic [RW*8-1:0] rw_data;

    reg_bank_arbiter_if bus ();

    reg_bank_arbiter #(
        .RW_REG_COUNT(RW),
        .RO_REG_COUNT(RO),
        .LOCK_MAX    (LOCK_MAX)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ro_data(ro_data),
        .rw_data(rw_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    bit         m_in_ack;      // an access completed at the last edge; next edge ignores requests
    bit         m_ack_a, m_ack_b;
    logic [7:0] m_rd_a, m_rd_b;
    logic [7:0] m_bank [RW];
    bit         m_last_b;      // most recent grant went to B
    int         m_streak;      // consecutive locked grants to m_streak_b's port
    bit         m_streak_b;

    function automatic logic [7:0] m_read(input int a);
        if (a < RW)      return m_bank[a];
        if (a < RW + RO) return ro_data[(a - RW)*8 +: 8];
        return 8'hFF;
    endfunction

    function automatic logic [RW*8-1:0] m_pack();
        logic [RW*8-1:0] v;
        for (int i = 0; i < RW; i++) v[i*8 +: 8] = m_bank[i];
        return v;
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit         pick_b;
        logic       w;
        logic [7:0] a, d;
        bit         lk;
        if (rst) begin
            m_in_ack = 0; m_ack_a = 0; m_ack_b = 0;
            m_rd_a = 8'h00; m_rd_b = 8'h00;
            for (int i = 0; i < RW; i++) m_bank[i] = 8'h00;
            m_last_b = 1; m_streak = 0; m_streak_b = 0;
            return;
        end
        m_ack_a = 0; m_ack_b = 0;
        if (m_in_ack) begin m_in_ack = 0; return; end
        if (!bus.req_a && !bus.req_b) return;
        if (bus.req_a && bus.req_b) begin
            pick_b = !m_last_b;
            if (LOCK_ON && m_streak > 0 && m_streak < LOCK_MAX) pick_b = m_streak_b;
        end else begin
            pick_b = bus.req_b;
        end
        w  = pick_b ? bus.we_b    : bus.we_a;
        a  = pick_b ? bus.addr_b  : bus.addr_a;
        d  = pick_b ? bus.wdata_b : bus.wdata_a;
        lk = pick_b ? bus.lock_b  : bus.lock_a;
        if (w) begin
            if (int'(a) < RW) m_bank[a] = d;
        end else if (pick_b) m_rd_b = m_read(int'(a));
        else                 m_rd_a = m_read(int'(a));
        if (pick_b) m_ack_b = 1; else m_ack_a = 1;
        m_last_b = pick_b;
        m_in_ack = 1;
        if (lk) begin
            if (m_streak > 0 && m_streak_b == pick_b)
                m_streak = (m_streak + 1 > LOCK_MAX) ? LOCK_MAX : m_streak + 1;
            else
                m_streak = 1;
            m_streak_b = pick_b;
        end else begin
            m_streak = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [RW*8-1:0] obs, input logic [RW*8-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ack_a",   bus.ack_a,   m_ack_a);
        chk("ack_b",   bus.ack_b,   m_ack_b);
        chk("rdata_a", bus.rdata_a, m_rd_a);
        chk("rdata_b", bus.rdata_b, m_rd_b);
        chk("rw_data", rw_data,     m_pack());
    endtask

    task automatic do_reset();
        rst = 1;
        bus.req_a = 0; bus.req_b = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic xact_a(input logic w, input logic [7:0] a, input logic [7:0] d, output bit acked);
        acked = 0;
        bus.req_a = 1; bus.we_a = w; bus.addr_a = a; bus.wdata_a = d; bus.lock_a = 0;
        for (int k = 0; k < 6 && !acked; k++) begin
            step();
            if (bus.ack_a === 1'b1) acked = 1;
        end
        bus.req_a = 0;
        step();
    endtask

    function automatic logic [7:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 15));
    endfunction

    task automatic new_req_a();
        bus.req_a = 1; bus.we_a = 1'($urandom); bus.addr_a = rnd_addr();
        bus.wdata_a = 8'($urandom); bus.lock_a = 1'($urandom);
    endtask

    task automatic new_req_b();
        bus.req_b = 1; bus.we_b = 1'($urandom); bus.addr_b = rnd_addr();
        bus.wdata_b = 8'($urandom); bus.lock_b = 1'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acked;
        bit got [16];
        int n_got;
        rst = 1; ro_data = 8'hC3;
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0; bus.lock_a = 0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0; bus.lock_b = 0;

        // Reset state
        do_reset();
        chk("rst_ack_a", bus.ack_a, 1'b0);
        chk("rst_rw_data", rw_data, '0);

        // Single write on A
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'd3; bus.wdata_a = 8'h5A;
        step();
        chk("w3_ack_a", bus.ack_a, 1'b1);
        chk("w3_ack_b", bus.ack_b, 1'b0);
        chk("w3_byte", rw_data[31:24], 8'h5A);
        bus.req_a = 0;
        step();
        chk("w3_ack_a_low", bus.ack_a, 1'b0);

        // Simultaneous reads after reset: A first, B two cycles later
        do_reset();
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 8'd3;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 8'd5;
        step();
        chk("tie_ack_a", bus.ack_a, 1'b1);
        chk("tie_ack_b0", bus.ack_b, 1'b0);
        bus.req_a = 0;
        step();
        chk("tie_ack_b1", bus.ack_b, 1'b0);
        step();
        chk("tie_ack_b2", bus.ack_b, 1'b1);
        bus.req_b = 0;
        step();

        // Read-only and unmapped decode
        do_reset();
        xact_a(1, 8'd11, 8'h77, acked);
        xact_a(0, 8'd12, 8'h00, acked);
        chk("ro_ack", acked, 1'b1);
        chk("ro_rdata", bus.rdata_a, 8'hC3);
        xact_a(0, 8'd13, 8'h00, acked);
        chk("unmapped_rdata", bus.rdata_a, 8'hFF);
        xact_a(1, 8'd12, 8'h11, acked);
        chk("ro_write_ack", acked, 1'b1);
        chk("ro_write_bank", rw_data, {8'h77, 88'h0});

        // Reset on the grant edge wins over the write
        do_reset();
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 8'd0; bus.wdata_a = 8'hAA;
        rst = 1;
        step();
        chk("rstgrant_ack", bus.ack_a, 1'b0);
        rst = 0; bus.req_a = 0;
        step();
        chk("rstgrant_ack_after", bus.ack_a, 1'b0);
        chk("rstgrant_byte", rw_data[7:0], 8'h00);

        // Continuous requests, A locking
        do_reset();
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 8'd1; bus.lock_a = 1;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 8'd2; bus.lock_b = 0;
        n_got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.ack_a === 1'b1 && n_got < 16) begin got[n_got] = 0; n_got++; end
            if (bus.ack_b === 1'b1 && n_got < 16) begin got[n_got] = 1; n_got++; end
        end
        bus.req_a = 0; bus.req_b = 0; bus.lock_a = 0;
        chk("lock_grant_count", n_got, 10);
        for (int i = 0; i < 10; i++) begin
            bit e;
            e = LOCK_ON ? (i % 5 == 4) : (i % 2 == 1);
            chk($sformatf("lock_grant_%0d", i), got[i], e);
        end
        step();

        // Randomized traffic
        do_reset();
        ro_data = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            if (!bus.req_a) begin
                if ($urandom_range(0, 2) == 0) new_req_a();
            end else if (m_in_ack && $urandom_range(0, 5) == 0) begin
                bus.req_a = 0;   // withdrawn before being sampled
            end
            if (!bus.req_b) begin
                if ($urandom_range(0, 2) == 0) new_req_b();
            end else if (m_in_ack && $urandom_range(0, 5) == 0) begin
                bus.req_b = 0;
            end
            rst = ($urandom_range(0, 79) == 0);
            step();
            rst = 0;
            if (m_ack_a) begin
                if ($urandom_range(0, 3) == 0) new_req_a(); else bus.req_a = 0;
            end
            if (m_ack_b) begin
                if ($urandom_range(0, 3) == 0) new_req_b(); else bus.req_b = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter RW_REG_COUNT, default 12, number of read-write byte registers owned by the block.
REQ-002 SHALL have parameter RO_REG_COUNT, default 1, number of read-only byte registers, addressed above the RW range.
REQ-003 SHALL have parameter LOCK_MAX, default 4, maximum consecutive locked grants to one port.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req_a/req_b  input  1  access request, SPI-side port A / internal port B, held until ack.
REQ-007 SHALL have ports we_a/we_b  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr_a/addr_b  input  8  byte address.
REQ-009 SHALL have ports wdata_a/wdata_b  input  8  write data.
REQ-010 SHALL have ports lock_a/lock_b  input  1  burst-lock hint, used only with REG_ARB_LOCK_EN.
REQ-011 SHALL have ports ack_a/ack_b  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports rdata_a/rdata_b  output  8  read data, valid while the matching ack is high.
REQ-013 SHALL have port ro_data  input  RO_REG_COUNT*8  flattened read-only bytes; byte i at bits [8i+7:8i].
REQ-014 SHALL have port rw_data  output  RW_REG_COUNT*8  flattened register bank; byte i at bits [8i+7:8i].

Function
REQ-015 SHALL implement FSM states IDLE and ACK; reset state IDLE.
REQ-016 In IDLE with no request, SHALL stay in IDLE and hold all outputs except ack, which is 0.
REQ-017 In IDLE with exactly one request, SHALL grant that port, perform its access at that clock edge, and go to ACK.
REQ-018 With both requests in IDLE, SHALL grant the port not granted last (round-robin pointer `last`, updated on every grant).
REQ-019 Each access SHALL be performed once per grant: latency from req sampled high in IDLE to ack high is exactly 1 cycle.
REQ-020 In ACK, SHALL raise only the granted port's ack for exactly one cycle, ignore all requests, then return to IDLE; peak throughput is one access per 2 cycles.
REQ-021 Write with addr < RW_REG_COUNT SHALL update rw_data byte addr; the new value is visible in the ACK cycle.
REQ-022 Write with addr >= RW_REG_COUNT (RO or unmapped) SHALL leave the bank unchanged and still be acked.
REQ-023 Read SHALL return rw_data byte addr if addr < RW_REG_COUNT; ro_data byte (addr-RW_REG_COUNT) if addr < RW_REG_COUNT+RO_REG_COUNT; else 8'hFF.
REQ-024 Read data SHALL be sampled at the grant edge; rdata of the non-granted port SHALL hold its previous value.
REQ-025 A request dropped before being sampled in IDLE SHALL cause no access and no ack.
REQ-026 A requester still asserting req in the IDLE cycle after its ack SHALL be treated as a new request.

Reset
REQ-027 With rst high at a clock edge, SHALL set state IDLE, rw_data all 0, ack_a/ack_b 0, rdata_a/rdata_b 0, `last` = B (A wins first tie), lock counter 0.
REQ-028 Reset SHALL take priority over any access sampled at the same edge: no write is applied and no ack follows.
REQ-029 Reset asserted during ACK SHALL clear ack at that edge.

Configuration
REQ-030 Macro REG_ARB_LOCK_EN defined: if the granted port had lock high at its grant edge and requests again in the next IDLE, SHALL grant it again regardless of the round-robin pointer, up to LOCK_MAX consecutive grants; on reaching LOCK_MAX with the other port requesting, SHALL grant the other port and clear the counter.
REQ-031 The lock counter SHALL clear whenever the other port is granted or the owner is granted with lock low.
REQ-032 Macro REG_ARB_LOCK_EN undefined: lock_a/lock_b SHALL be ignored and arbitration is pure round-robin.

Verification
REQ-033 Reset, then req_a write addr 3 data 8'h5A -> ack_a high 1 cycle later, rw_data[31:24] = 8'h5A, ack_b stays 0.
REQ-034 req_a and req_b both read in same IDLE cycle after reset -> A acked first, B acked 2 cycles after A's ack.
REQ-035 RW_REG_COUNT=12, ro_data=8'hC3: read addr 12 -> rdata 8'hC3; read addr 13 -> rdata 8'hFF; write addr 12 data 8'h11 -> acked, bank unchanged.
REQ-036 Write addr 0 data 8'hAA with rst asserted on the grant edge -> no ack, rw_data[7:0] = 8'h00.
REQ-037 REG_ARB_LOCK_EN, LOCK_MAX=4, A requests continuously with lock_a=1 and B requests continuously -> A granted 4 times in a row, then B; without the macro -> A, B alternate.
